// File: rtl/clock_div_buffer_if.sv
// Ratio-configuration handshake bundle for clock_div_buffer.
// The master offers cfg_div with cfg_valid; the slave answers with cfg_ready.
interface clock_div_buffer_if #(
  parameter int WIDTH = 8
);
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_div;
  logic             cfg_ready;

  modport master (
    output cfg_valid,
    output cfg_div,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    output cfg_ready
  );
endinterface

// File: rtl/clock_div_buffer.sv
// Glitch-free registered clock divider with buffered ratio update.
// Optional macro CLKDIV_TICK_EN enables the period-start tick output.
module clock_div_buffer #(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 en,
  clock_div_buffer_if.slave    cfg,
  output logic                 clk_out,
  output logic                 running,
  output logic                 tick
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ratio_q, ratio_d;
  logic [WIDTH-1:0] pdiv_q, pdiv_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             run_q, run_d;

  logic [WIDTH-1:0] n_eff;
  logic [WIDTH-1:0] h_len;
  logic [WIDTH-1:0] cnt_inc;
  logic             wrap;
  logic             accept;
  logic             apply;

  // Ratios 0 and 1 cannot form a clock, so they behave as 2.
  assign n_eff   = (ratio_q < WIDTH'(2)) ? WIDTH'(2) : ratio_q;
  assign h_len   = n_eff - (n_eff >> 1);
  assign cnt_inc = cnt_q + WIDTH'(1);
  assign wrap    = (state_q == RUN) && (cnt_q == n_eff - WIDTH'(1));
  assign accept  = cfg.cfg_valid && !pend_q;
  assign apply   = pend_q && ((state_q == IDLE) || wrap);

  assign cfg.cfg_ready = ~pend_q;
  assign clk_out       = clk_q;
  assign running       = run_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clk_d   = clk_q;
    ratio_d = ratio_q;
    pdiv_d  = pdiv_q;
    pend_d  = pend_q;

    if (apply) begin
      ratio_d = pdiv_q;
      pend_d  = 1'b0;
    end
    if (accept) begin
      pend_d = 1'b1;
      pdiv_d = cfg.cfg_div;
    end

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        clk_d = 1'b0;
        if (en) begin
          state_d = RUN;
          clk_d   = 1'b1;
        end
      end
      RUN: begin
        if (wrap) begin
          cnt_d = '0;
          if (en) begin
            clk_d = 1'b1;
          end else begin
            state_d = IDLE;
            clk_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_inc;
          clk_d = (cnt_inc < h_len);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        clk_d   = 1'b0;
      end
    endcase

    run_d = (state_d == RUN);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      clk_q   <= 1'b0;
      run_q   <= 1'b0;
      ratio_q <= WIDTH'(RESET_DIV);
      pdiv_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clk_q   <= clk_d;
      run_q   <= run_d;
      ratio_q <= ratio_d;
      pdiv_q  <= pdiv_d;
      pend_q  <= pend_d;
    end
  end

`ifdef CLKDIV_TICK_EN
  logic tick_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= en && ((state_q == IDLE) || wrap);
    end
  end

  assign tick = tick_q;
`else
  assign tick = 1'b0;
`endif

endmodule

// File: tb/tb_clock_div_buffer.sv
// Randomized and directed bench for clock_div_buffer against a
// period-queue reference model.
module tb_clock_div_buffer;

  localparam int W  = 8;
  localparam int RB = 3;
`ifdef CLKDIV_TICK_EN
  localparam bit TICK_ON = 1'b1;
`else
  localparam bit TICK_ON = 1'b0;
`endif

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  logic en     = 1'b0;
  logic clk_out;
  logic running;
  logic tick;

  clock_div_buffer_if #(.WIDTH(W)) cif ();

  clock_div_buffer #(
    .WIDTH    (W),
    .RESET_DIV(RB)
  ) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .en     (en),
    .cfg    (cif),
    .clk_out(clk_out),
    .running(running),
    .tick   (tick)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Each entry is one expected output cycle: [1]=tick, [0]=clk_out.
  logic [1:0] q[$];
  bit         m_pend;
  int         m_pval;
  int         m_ratio;

  function automatic void model_reset();
    q.delete();
    m_pend  = 1'b0;
    m_pval  = 0;
    m_ratio = RB;
  endfunction

  function automatic void fill_period();
    int n;
    int h;
    n = (m_ratio < 2) ? 2 : m_ratio;
    h = n - n / 2;
    for (int i = 0; i < n; i++) begin
      q.push_back({1'(i == 0), 1'(i < h)});
    end
  endfunction

  function automatic void model_edge(bit e, bit v, int d);
    bit acc;
    acc = v && !m_pend;
    if (q.size() != 0) void'(q.pop_front());
    if (q.size() == 0) begin
      if (m_pend) begin
        m_ratio = m_pval;
        m_pend  = 1'b0;
      end
      if (e) fill_period();
    end
    if (acc) begin
      m_pend = 1'b1;
      m_pval = d;
    end
  endfunction

  function automatic logic [3:0] exp_vec();
    if (q.size() != 0)
      return {q[0][0], q[0][1] & TICK_ON, 1'b1, !m_pend};
    return {3'b000, !m_pend};
  endfunction

  function automatic logic [3:0] act_vec();
    return {clk_out, tick, running, cif.cfg_ready};
  endfunction

  task automatic cycle();
    @(posedge clk_in);
    model_edge(en, cif.cfg_valid, int'(cif.cfg_div));
    #1;
  endtask

  task automatic load_ratio(input int r);
    en            = 1'b0;
    cif.cfg_valid = 1'b1;
    cif.cfg_div   = W'(r);
    cycle();
    cif.cfg_valid = 1'b0;
    cycle();
  endtask

  task automatic drain();
    en = 1'b0;
    repeat (12) cycle();
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    checks++;
    if (act_vec() !== 4'b0001) begin
      errors++;
      $display("FAIL reset_state act %b exp %b", act_vec(), 4'b0001);
    end
    @(negedge clk_in);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cycle();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_idle k%0d act %b exp %b", k, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_ratio4();
    load_ratio(4);
    en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL ratio4 k%0d act %b exp %b", k, act_vec(), exp_vec());
      end
      checks++;
      if ({clk_out, tick, running} !==
          {1'((k % 4) < 2), 1'(TICK_ON && (k % 4) == 0), 1'b1}) begin
        errors++;
        $display("FAIL ratio4_pat k%0d clk %b tick %b run %b", k, clk_out, tick, running);
      end
    end
    drain();
  endtask

  task automatic test_ratio5_0();
    load_ratio(5);
    en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      checks++;
      if (clk_out !== 1'((k % 5) < 3) || act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL ratio5 k%0d act %b exp %b", k, act_vec(), exp_vec());
      end
    end
    drain();
    load_ratio(0);
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      checks++;
      if (clk_out !== 1'((k % 2) == 0) || act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL ratio0 k%0d act %b exp %b", k, act_vec(), exp_vec());
      end
    end
    drain();
  endtask

  task automatic test_retune();
    load_ratio(4);
    en = 1'b1;
    cycle();
    cycle();
    cif.cfg_valid = 1'b1;
    cif.cfg_div   = W'(6);
    cycle();
    cif.cfg_valid = 1'b0;
    for (int k = 0; k < 14; k++) begin
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL retune k%0d act %b exp %b", k, act_vec(), exp_vec());
      end
      cycle();
    end
    drain();
  endtask

  task automatic test_stop();
    int highs;
    highs = 0;
    load_ratio(6);
    en = 1'b1;
    cycle();
    highs += int'(clk_out);
    cycle();
    highs += int'(clk_out);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      highs += int'(clk_out);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL stop k%0d act %b exp %b", k, act_vec(), exp_vec());
      end
    end
    checks++;
    if (highs !== 3) begin
      errors++;
      $display("FAIL stop_highs act %0d exp 3", highs);
    end
  endtask

  task automatic test_async_reset();
    load_ratio(8);
    en = 1'b1;
    repeat (3) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (act_vec() !== 4'b0001) begin
      errors++;
      $display("FAIL async_reset act %b exp %b", act_vec(), 4'b0001);
    end
    @(negedge clk_in);
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      cycle();
      checks++;
      if (clk_out !== 1'((k % RB) < (RB - RB / 2)) || act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL post_reset k%0d act %b exp %b", k, act_vec(), exp_vec());
      end
    end
    drain();
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      en            = ($urandom_range(0, 3) != 0);
      cif.cfg_valid = ($urandom_range(0, 3) == 0);
      cif.cfg_div   = W'($urandom_range(0, 9));
      cycle();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random k%0d act %b exp %b", k, act_vec(), exp_vec());
      end
    end
    cif.cfg_valid = 1'b0;
    drain();
  endtask

  initial begin
    cif.cfg_valid = 1'b0;
    cif.cfg_div   = '0;
    test_reset();
    test_ratio4();
    test_ratio5_0();
    test_retune();
    test_stop();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
